decode_cycle: RTL and testbench
===============================

# decode_cycle

Second pipeline stage of the five-stage RV32I core. Receives the fetch-stage pipeline outputs (InstrD, PCD, PCPlus4D) and decodes the instruction. Reads two operands from a 32x32 register file that is written by the writeback stage, and sign-extends the immediate. All results are registered into the ID/EX pipeline register, which drives the execute stage.

## Interface
- No parameters. Register count (32) and data width (32) are fixed.
- clk  in  1  stage clock. The ID/EX register and register file update on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction from fetch. The value is 0 while fetch is in reset.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  writeback write enable.
- RDW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- FlushE  in  1  synchronous bubble insert into the ID/EX register.
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each  registered control signals.
- ResultSrcE  out  2  result select: 00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E  out  32  register operands.
- ImmExtE  out  32  sign-extended immediate.
- RS1E, RS2E, RDE  out  5 each  instruction register fields.
- PCE, PCPlus4E  out  32  PC values passed through.

## Operation
**Decode by opcode.** Columns are RegWrite / ImmSrc / ALUSrc / MemWrite / ResultSrc / Branch / Jump / ALUOp.
- 0000011 lw: 1 / I / 1 / 0 / 01 / 0 / 0 / add.
- 0100011 sw: 0 / S / 1 / 1 / 00 / 0 / 0 / add.
- 0110011 R-type: 1 / – / 0 / 0 / 00 / 0 / 0 / funct.
- 0010011 I-ALU: 1 / I / 1 / 0 / 00 / 0 / 0 / funct.
- 1100011 beq: 0 / B / 0 / 0 / 00 / 1 / 0 / sub.
- 1101111 jal: 1 / J / 0 / 0 / 10 / 0 / 1 / add.
- Any other opcode, including 0x00000000: all control outputs 0 (NOP).

**ALU function decode (funct3).**
- 000: sub only when R-type and funct7[5]=1; otherwise add.
- 010: slt. 110: or. 111: and.
- Any other funct3: add.

**Immediate extension.** Every format sign-extends from instr[31].
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R-type and NOP: ImmExt = 0.

**Register file.**
- Asynchronous reads on instr[19:15] and instr[24:20].
- x0 always reads 0.
- Writes happen on the rising clk edge when RegWriteW=1 and RDW≠0. A write with RDW=0 is discarded.
- Write-through bypass: when RegWriteW=1, RDW≠0 and RDW equals a read address in the same cycle, that read returns ResultW.
- Reset clears all 32 registers to 0.

**Field capture.** RS1E=instr[19:15], RS2E=instr[24:20], RDE=instr[11:7]. These are captured for every opcode.

## Timing
- **Latency.** Exactly 1 cycle. Outputs reflect the InstrD/PCD/PCPlus4D present before rising edge N starting after edge N. No stall input: the register loads on every edge.
- **Reset (rst=0).** Immediately and asynchronously, every output goes to 0 and every register-file entry goes to 0. This holds while rst=0, including mid-operation. On the first edge after rst rises, the stage captures the current InstrD.
- **FlushE=1 at an edge.** The ID/EX register loads all zeros, a NOP with PCE=0. The register-file write in the same edge still occurs.
- **FlushE and rst together.** Reset dominates.
- **Writeback to a register read by the same InstrD.** The bypassed ResultW is captured, not the stale value.

## Test plan
- **Reset.** Hold rst=0 with random inputs → all outputs 0. Release rst, InstrD=0 → RegWriteE=MemWriteE=BranchE=JumpE=0.
- **addi.** InstrD=0x00700293 (addi x5,x0,7), PCD=0x10 → next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=7, RDE=5, RD1E=0, PCE=0x10, PCPlus4E=0x14.
- **Write then R-type read.** Write x1=5 and x2=3 via W ports. Then InstrD=0x402081B3 (sub x3,x1,x2) → RD1E=5, RD2E=3, ALUControlE=001, ALUSrcE=0, RDE=3.
- **sw and beq.** InstrD=0x0020A423 (sw x2,8(x1)) → MemWriteE=1, RegWriteE=0, ImmExtE=8. Then InstrD=0xFE208CE3 (beq x1,x2,-8) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8.
- **Bypass and x0 protection.**
  - RegWriteW=1, RDW=1, ResultW=0x12345678 while InstrD reads rs1=x1 → RD1E=0x12345678 the same edge.
  - RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF → a later read of x0 returns 0.
- **Flush and mid-operation reset.** jal (0x008000EF) with FlushE=1 → all outputs 0. Same instruction with FlushE=0 → JumpE=1, ResultSrcE=10, ImmExtE=8. Pulse rst low mid-stream → outputs clear immediately and x1 reads 0 afterwards.

Source files
------------

// File: rtl/decode_cycle_if.sv
// Signal bundle between the RV32I decode stage and its neighbours: fetch inputs,
// writeback port, flush control and the ID/EX pipeline register outputs.
interface decode_cycle_if;
  // No valid/ready handshake: the ID/EX register loads on every clock edge.
  // FlushE turns that load into a bubble; nothing can stall it.
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        FlushE;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        BranchE;
  logic        JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  RS1E;
  logic [4:0]  RS2E;
  logic [4:0]  RDE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, 32x32 register file with write-through
// bypass, immediate extension, and the ID/EX pipeline register.
module decode_cycle (
  input logic           clk,
  input logic           rst,
  decode_cycle_if.slave bus
);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} immSrc_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluOp_t;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic        aluSrc;
    logic        branch;
    logic        jump;
    logic [1:0]  resultSrc;
    logic [2:0]  aluControl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immExt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } idex_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign instr  = bus.InstrD;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  logic    regWrite;
  logic    memWrite;
  logic    aluSrc;
  logic    branch;
  logic    jump;
  logic [1:0] resultSrc;
  immSrc_t immSrc;
  aluOp_t  aluOp;
  logic    isRType;

  always_comb begin
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    aluSrc    = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    resultSrc = 2'b00;
    immSrc    = IMM_NONE;
    aluOp     = ALUOP_ADD;
    isRType   = 1'b0;
    case (opcode)
      7'b0000011: begin regWrite = 1'b1; immSrc = IMM_I; aluSrc = 1'b1; resultSrc = 2'b01; end
      7'b0100011: begin immSrc = IMM_S; aluSrc = 1'b1; memWrite = 1'b1; end
      7'b0110011: begin regWrite = 1'b1; aluOp = ALUOP_FUNCT; isRType = 1'b1; end
      7'b0010011: begin regWrite = 1'b1; immSrc = IMM_I; aluSrc = 1'b1; aluOp = ALUOP_FUNCT; end
      7'b1100011: begin immSrc = IMM_B; branch = 1'b1; aluOp = ALUOP_SUB; end
      7'b1101111: begin regWrite = 1'b1; immSrc = IMM_J; resultSrc = 2'b10; jump = 1'b1; end
      default: ;
    endcase
  end

  logic [2:0] aluControl;

  // funct7[5] selects sub only for register-register ops; addi ignores it.
  always_comb begin
    aluControl = 3'b000;
    case (aluOp)
      ALUOP_SUB: aluControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  aluControl = (isRType && instr[30]) ? 3'b001 : 3'b000;
          3'b010:  aluControl = 3'b101;
          3'b110:  aluControl = 3'b011;
          3'b111:  aluControl = 3'b010;
          default: aluControl = 3'b000;
        endcase
      end
      default: aluControl = 3'b000;
    endcase
  end

  logic [31:0] immExt;

  always_comb begin
    immExt = 32'h0;
    case (immSrc)
      IMM_I:   immExt = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   immExt = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   immExt = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   immExt = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immExt = 32'h0;
    endcase
  end

  logic [31:0] regs [32];
  logic        wbActive;

  assign wbActive = bus.RegWriteW && (bus.RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wbActive) begin
      regs[bus.RDW] <= bus.ResultW;
    end
  end

  logic [31:0] rd1;
  logic [31:0] rd2;

  // Same-cycle writeback wins over the stored value so the stage sees fresh data.
  always_comb begin
    rd1 = 32'h0;
    rd2 = 32'h0;
    if (rs1 != 5'd0) rd1 = (wbActive && bus.RDW == rs1) ? bus.ResultW : regs[rs1];
    if (rs2 != 5'd0) rd2 = (wbActive && bus.RDW == rs2) ? bus.ResultW : regs[rs2];
  end

  idex_t idexNext;
  idex_t idex;

  always_comb begin
    idexNext            = '0;
    idexNext.regWrite   = regWrite;
    idexNext.memWrite   = memWrite;
    idexNext.aluSrc     = aluSrc;
    idexNext.branch     = branch;
    idexNext.jump       = jump;
    idexNext.resultSrc  = resultSrc;
    idexNext.aluControl = aluControl;
    idexNext.rd1        = rd1;
    idexNext.rd2        = rd2;
    idexNext.immExt     = immExt;
    idexNext.rs1        = rs1;
    idexNext.rs2        = rs2;
    idexNext.rd         = instr[11:7];
    idexNext.pc         = bus.PCD;
    idexNext.pcPlus4    = bus.PCPlus4D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            idex <= '0;
    else if (bus.FlushE) idex <= '0;
    else                 idex <= idexNext;
  end

  assign bus.RegWriteE   = idex.regWrite;
  assign bus.MemWriteE   = idex.memWrite;
  assign bus.ALUSrcE     = idex.aluSrc;
  assign bus.BranchE     = idex.branch;
  assign bus.JumpE       = idex.jump;
  assign bus.ResultSrcE  = idex.resultSrc;
  assign bus.ALUControlE = idex.aluControl;
  assign bus.RD1E        = idex.rd1;
  assign bus.RD2E        = idex.rd2;
  assign bus.ImmExtE     = idex.immExt;
  assign bus.RS1E        = idex.rs1;
  assign bus.RS2E        = idex.rs2;
  assign bus.RDE         = idex.rd;
  assign bus.PCE         = idex.pc;
  assign bus.PCPlus4E    = idex.pcPlus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized
// instruction streams compared against a behavioural decode model.
module tb_decode_cycle;

  logic clk;
  logic rst;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic        aluSrc;
    logic        branch;
    logic        jump;
    logic [1:0]  resultSrc;
    logic [2:0]  aluControl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } outs_t;

  localparam int OUTW = $bits(outs_t);

  logic [OUTW-1:0] exp_q[$];
  logic [31:0]     mregs [32];
  int              passCount;
  int              checkCount;

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext(input logic [31:0] raw, input int bits);
    longint v;
    v = longint'(raw);
    if (v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (bus.RegWriteW && bus.RDW == a) return bus.ResultW;
    return mregs[a];
  endfunction

  function automatic logic [2:0] functAlu(input logic [31:0] instr, input bit isR);
    case (instr[14:12])
      3'd0:    return (isR && instr[30]) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic outs_t model();
    outs_t       o;
    logic [31:0] i;
    i = bus.InstrD;
    o = '0;
    if (bus.FlushE) return o;
    o.rs1  = i[19:15];
    o.rs2  = i[24:20];
    o.rd   = i[11:7];
    o.rd1  = modelRead(i[19:15]);
    o.rd2  = modelRead(i[24:20]);
    o.pc   = bus.PCD;
    o.pcp4 = bus.PCPlus4D;
    case (i[6:0])
      7'h03: begin
        o.regWrite = 1; o.aluSrc = 1; o.resultSrc = 2'd1;
        o.imm = sext({20'h0, i[31:20]}, 12);
      end
      7'h23: begin
        o.memWrite = 1; o.aluSrc = 1;
        o.imm = sext({20'h0, i[31:25], i[11:7]}, 12);
      end
      7'h33: begin
        o.regWrite = 1; o.aluControl = functAlu(i, 1'b1);
      end
      7'h13: begin
        o.regWrite = 1; o.aluSrc = 1; o.aluControl = functAlu(i, 1'b0);
        o.imm = sext({20'h0, i[31:20]}, 12);
      end
      7'h63: begin
        o.branch = 1; o.aluControl = 3'd1;
        o.imm = sext({19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      end
      7'h6f: begin
        o.regWrite = 1; o.jump = 1; o.resultSrc = 2'd2;
        o.imm = sext({11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o.regWrite   = bus.RegWriteE;
    o.memWrite   = bus.MemWriteE;
    o.aluSrc     = bus.ALUSrcE;
    o.branch     = bus.BranchE;
    o.jump       = bus.JumpE;
    o.resultSrc  = bus.ResultSrcE;
    o.aluControl = bus.ALUControlE;
    o.rd1        = bus.RD1E;
    o.rd2        = bus.RD2E;
    o.imm        = bus.ImmExtE;
    o.rs1        = bus.RS1E;
    o.rs2        = bus.RS2E;
    o.rd         = bus.RDE;
    o.pc         = bus.PCE;
    o.pcp4       = bus.PCPlus4E;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.InstrD   = instr;
    bus.PCD      = pc;
    bus.PCPlus4D = pc + 32'd4;
  endtask

  task automatic driveWb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.RegWriteW = en;
    bus.RDW       = rd;
    bus.ResultW   = data;
  endtask

  // Predict the edge's capture, update the model register file, then cross the edge.
  task automatic tick();
    exp_q.push_back(model());
    if (bus.RegWriteW && bus.RDW != 5'd0) mregs[bus.RDW] = bus.ResultW;
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic checkModel(input string name);
    outs_t e;
    outs_t a;
    checkCount++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: expectation queue empty", name);
    end else begin
      e = exp_q.pop_front();
      a = actual();
      if (a !== e) $display("FAIL %s: got %h expected %h", name, a, e);
      else passCount++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    outs_t a;
    rst = 1'b1;
    bus.FlushE = 1'b0;
    driveWb(1'b0, 5'd0, 32'h0);
    drive(32'h0, 32'h0);
    #2;
    rst = 1'b0;
    clearModel();
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom);
      driveWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      bus.FlushE = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      a = actual();
      checkCount++;
      if (a !== '0) $display("FAIL reset_hold: got %h expected 0", a);
      else passCount++;
    end
    drive(32'h0, $urandom);
    driveWb(1'b0, 5'd0, 32'h0);
    bus.FlushE = 1'b0;
    rst = 1'b1;
    tick();
    checkCount++;
    if ({bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE} !== 4'b0)
      $display("FAIL reset_release_ctrl: got %b expected 0000",
               {bus.RegWriteE, bus.MemWriteE, bus.BranchE, bus.JumpE});
    else passCount++;
    checkModel("reset_release_model");
  endtask

  task automatic test_addi();
    drive(32'h00700293, 32'h10);
    tick();
    checkCount++;
    if ({bus.RegWriteE, bus.ALUSrcE, bus.ALUControlE, bus.ImmExtE, bus.RDE, bus.RD1E, bus.PCE, bus.PCPlus4E}
        !== {1'b1, 1'b1, 3'b000, 32'd7, 5'd5, 32'd0, 32'h10, 32'h14})
      $display("FAIL addi: got rw=%b as=%b alu=%b imm=%h rd=%0d rd1=%h pc=%h pc4=%h expected 1 1 000 7 5 0 10 14",
               bus.RegWriteE, bus.ALUSrcE, bus.ALUControlE, bus.ImmExtE, bus.RDE, bus.RD1E, bus.PCE, bus.PCPlus4E);
    else passCount++;
    checkModel("addi_model");
  endtask

  task automatic test_rtype();
    driveWb(1'b1, 5'd1, 32'd5);
    drive(32'h0, 32'h20);
    tick();
    checkModel("wr_x1");
    driveWb(1'b1, 5'd2, 32'd3);
    tick();
    checkModel("wr_x2");
    driveWb(1'b0, 5'd0, 32'h0);
    drive(32'h402081B3, 32'h24);
    tick();
    checkCount++;
    if ({bus.RD1E, bus.RD2E, bus.ALUControlE, bus.ALUSrcE, bus.RDE}
        !== {32'd5, 32'd3, 3'b001, 1'b0, 5'd3})
      $display("FAIL sub: got rd1=%h rd2=%h alu=%b as=%b rd=%0d expected 5 3 001 0 3",
               bus.RD1E, bus.RD2E, bus.ALUControlE, bus.ALUSrcE, bus.RDE);
    else passCount++;
    checkModel("sub_model");
  endtask

  task automatic test_sw_beq();
    drive(32'h0020A423, 32'h28);
    tick();
    checkCount++;
    if ({bus.MemWriteE, bus.RegWriteE, bus.ImmExtE} !== {1'b1, 1'b0, 32'd8})
      $display("FAIL sw: got mw=%b rw=%b imm=%h expected 1 0 00000008",
               bus.MemWriteE, bus.RegWriteE, bus.ImmExtE);
    else passCount++;
    checkModel("sw_model");
    drive(32'hFE208CE3, 32'h2C);
    tick();
    checkCount++;
    if ({bus.BranchE, bus.ALUControlE, bus.ImmExtE} !== {1'b1, 3'b001, 32'hFFFFFFF8})
      $display("FAIL beq: got br=%b alu=%b imm=%h expected 1 001 fffffff8",
               bus.BranchE, bus.ALUControlE, bus.ImmExtE);
    else passCount++;
    checkModel("beq_model");
  endtask

  task automatic test_bypass();
    driveWb(1'b1, 5'd1, 32'h12345678);
    drive(32'h00008313, 32'h30);
    tick();
    checkCount++;
    if (bus.RD1E !== 32'h12345678)
      $display("FAIL bypass_rs1: got %h expected 12345678", bus.RD1E);
    else passCount++;
    checkModel("bypass_model");
    driveWb(1'b1, 5'd0, 32'hFFFFFFFF);
    drive(32'h000003B3, 32'h34);
    tick();
    checkCount++;
    if ({bus.RD1E, bus.RD2E} !== 64'h0)
      $display("FAIL x0_same_cycle: got %h %h expected 0 0", bus.RD1E, bus.RD2E);
    else passCount++;
    driveWb(1'b0, 5'd0, 32'h0);
    tick();
    checkCount++;
    if ({bus.RD1E, bus.RD2E} !== 64'h0)
      $display("FAIL x0_later: got %h %h expected 0 0", bus.RD1E, bus.RD2E);
    else passCount++;
    void'(exp_q.pop_front());
    checkModel("x0_later_model");
  endtask

  task automatic test_flush_reset();
    outs_t a;
    drive(32'h008000EF, 32'h40);
    bus.FlushE = 1'b1;
    tick();
    a = actual();
    checkCount++;
    if (a !== '0) $display("FAIL flush: got %h expected 0", a);
    else passCount++;
    void'(exp_q.pop_front());
    bus.FlushE = 1'b0;
    tick();
    checkCount++;
    if ({bus.JumpE, bus.ResultSrcE, bus.ImmExtE, bus.RegWriteE} !== {1'b1, 2'b10, 32'd8, 1'b1})
      $display("FAIL jal: got j=%b rs=%b imm=%h rw=%b expected 1 10 00000008 1",
               bus.JumpE, bus.ResultSrcE, bus.ImmExtE, bus.RegWriteE);
    else passCount++;
    checkModel("jal_model");
    #2;
    rst = 1'b0;
    #1;
    a = actual();
    checkCount++;
    if (a !== '0) $display("FAIL async_reset: got %h expected 0", a);
    else passCount++;
    clearModel();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(32'h00008313, 32'h50);
    tick();
    checkCount++;
    if (bus.RD1E !== 32'h0) $display("FAIL x1_after_reset: got %h expected 0", bus.RD1E);
    else passCount++;
    checkModel("after_reset_model");
  endtask

  task automatic test_random();
    logic [6:0]  ops [7];
    logic [31:0] instr;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h00};
    for (int k = 0; k < 400; k++) begin
      instr = $urandom;
      if ($urandom_range(0, 9) != 0) instr[6:0] = ops[$urandom_range(0, 6)];
      if (instr[6:0] == 7'h33) instr[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'b0};
      drive(instr, $urandom);
      driveWb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) == 0) bus.RDW = instr[19:15];
      else if ($urandom_range(0, 3) == 0) bus.RDW = instr[24:20];
      bus.FlushE = ($urandom_range(0, 7) == 0);
      tick();
      checkModel("random");
    end
    bus.FlushE = 1'b0;
    driveWb(1'b0, 5'd0, 32'h0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    passCount  = 0;
    checkCount = 0;
    test_reset();
    test_addi();
    test_rtype();
    test_sw_beq();
    test_bypass();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
